// File: rtl/mips_pkg.sv
// Shared fetch-side types and constants.
// Imported by the fetch stage and its output register.
package mips_pkg;

   typedef enum logic [1:0] {
      WARM = 2'd0,
      RUN  = 2'd1,
      HALT = 2'd2
   } fetch_state_t;

   localparam int INSTR_W = 32;
   localparam int PC_W    = 32;

   localparam logic [PC_W-1:0]    DEFAULT_RESET_PC = 32'h0000_0000;
   localparam logic [INSTR_W-1:0] NOP              = 32'h0000_0000;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID output register: instruction, pc, pc+4 and valid.
// load captures a new entry; flush drops valid; otherwise hold.
import mips_pkg::*;

module if_id_reg #(
   parameter int DATA_W = INSTR_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load,
   input  logic              flush,
   input  logic [DATA_W-1:0] instr_in,
   input  logic [PC_W-1:0]   pc_in,
   output logic              valid,
   output logic [DATA_W-1:0] instr,
   output logic [PC_W-1:0]   pc,
   output logic [PC_W-1:0]   pc_plus4
);

   logic              valid_d, valid_q;
   logic [DATA_W-1:0] instr_d, instr_q;
   logic [PC_W-1:0]   pc_d, pc_q;
   logic [PC_W-1:0]   pc_plus4_d, pc_plus4_q;

   always_comb begin
      valid_d    = valid_q;
      instr_d    = instr_q;
      pc_d       = pc_q;
      pc_plus4_d = pc_plus4_q;
      if (flush) begin
         valid_d = 1'b0;
      end else if (load) begin
         valid_d    = 1'b1;
         instr_d    = instr_in;
         pc_d       = pc_in;
         pc_plus4_d = pc_in + 32'd4;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q    <= 1'b0;
         instr_q    <= NOP;
         pc_q       <= '0;
         pc_plus4_q <= 32'd4;
      end else begin
         valid_q    <= valid_d;
         instr_q    <= instr_d;
         pc_q       <= pc_d;
         pc_plus4_q <= pc_plus4_d;
      end
   end

   assign valid    = valid_q;
   assign instr    = instr_q;
   assign pc       = pc_q;
   assign pc_plus4 = pc_plus4_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the byte PC, addresses instruction memory and
// hands captured words to decode through a valid/ready register.
import mips_pkg::*;

module instr_fetch_unit #(
   parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
   parameter int          ADDR_W   = 8,
   parameter int          DATA_W   = INSTR_W
) (
   input  logic              clk,
   input  logic              rst_n,
   output logic [ADDR_W-1:0] memAddr,
   input  logic [DATA_W-1:0] memData,
   output logic              outValid,
   input  logic              outReady,
   output logic [DATA_W-1:0] outInstr,
   output logic [31:0]       outPc,
   output logic [31:0]       outPcPlus4,
   input  logic              redirectEn,
   input  logic [31:0]       redirectPc,
   input  logic              haltReq,
   output logic              halted,
   output logic              misalignErr
);

   fetch_state_t state_d, state_q;
   logic [31:0]  pc_d, pc_q;
   logic         misalign_d, misalign_q;

   logic redirect;
   logic fire;
   logic load;
   logic flush;

   // Redirects are dead once halted; only reset leaves HALT.
   assign redirect = redirectEn && (state_q != HALT);
   assign fire     = !outValid || outReady;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= WARM;
         pc_q       <= RESET_PC;
         misalign_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         misalign_q <= misalign_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         WARM: begin
            if (redirect && haltReq) state_d = HALT;
            else if (redirect)       state_d = WARM;
            else if (haltReq)        state_d = HALT;
            else                     state_d = RUN;
         end
         RUN: begin
            if (redirect && haltReq) state_d = HALT;
            else if (redirect)       state_d = WARM;
            else if (haltReq)        state_d = HALT;
         end
         HALT:    state_d = HALT;
         default: state_d = WARM;
      endcase
   end

   always_comb begin
      pc_d       = pc_q;
      misalign_d = 1'b0;
      load       = 1'b0;
      flush      = 1'b0;
      if (redirect) begin
         pc_d       = redirectPc & ~32'h3;
         misalign_d = |redirectPc[1:0];
         flush      = 1'b1;
      end else if (state_q == RUN && !haltReq && fire) begin
         load = 1'b1;
         pc_d = pc_q + 32'd4;
      end else begin
         // Consumed with nothing new behind it: drop valid.
         flush = outValid && outReady;
      end
   end

   if_id_reg #(
      .DATA_W(DATA_W)
   ) u_if_id_reg (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (load),
      .flush    (flush),
      .instr_in (memData),
      .pc_in    (pc_q),
      .valid    (outValid),
      .instr    (outInstr),
      .pc       (outPc),
      .pc_plus4 (outPcPlus4)
   );

   assign memAddr     = pc_q[ADDR_W+1:2];
   assign halted      = (state_q == HALT);
   assign misalignErr = misalign_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a 256-word memory model
// whose word k holds k*0x11.
module tb_instr_fetch_unit;

   logic        clk;
   logic        rst_n;
   logic [7:0]  memAddr;
   logic [31:0] memData;
   logic        outValid;
   logic        outReady;
   logic [31:0] outInstr;
   logic [31:0] outPc;
   logic [31:0] outPcPlus4;
   logic        redirectEn;
   logic [31:0] redirectPc;
   logic        haltReq;
   logic        halted;
   logic        misalignErr;

   int tests;
   int fails;

   instr_fetch_unit dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .memAddr     (memAddr),
      .memData     (memData),
      .outValid    (outValid),
      .outReady    (outReady),
      .outInstr    (outInstr),
      .outPc       (outPc),
      .outPcPlus4  (outPcPlus4),
      .redirectEn  (redirectEn),
      .redirectPc  (redirectPc),
      .haltReq     (haltReq),
      .halted      (halted),
      .misalignErr (misalignErr)
   );

   assign memData = {24'h0, memAddr} * 32'h11;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic chk_out(input string tag, input logic v,
                          input logic [31:0] pc, input logic [31:0] ins,
                          input logic [7:0] ma);
      check({tag, ".valid"}, {31'h0, outValid}, {31'h0, v});
      check({tag, ".pc"}, outPc, pc);
      check({tag, ".pc4"}, outPcPlus4, pc + 32'd4);
      check({tag, ".instr"}, outInstr, ins);
      check({tag, ".addr"}, {24'h0, memAddr}, {24'h0, ma});
   endtask

   initial begin
      tests      = 0;
      fails      = 0;
      rst_n      = 1'b0;
      outReady   = 1'b1;
      redirectEn = 1'b0;
      redirectPc = 32'h0;
      haltReq    = 1'b0;

      // 1: reset state and streaming fetch
      @(negedge clk);
      chk_out("rst", 1'b0, 32'h0, 32'h0, 8'd0);
      check("rst.halted", {31'h0, halted}, 32'h0);
      check("rst.mis", {31'h0, misalignErr}, 32'h0);
      rst_n = 1'b1;
      step();
      check("warm.valid", {31'h0, outValid}, 32'h0);
      check("warm.addr", {24'h0, memAddr}, 32'h0);
      step();
      chk_out("f0", 1'b1, 32'h0, 32'h0, 8'd1);
      step();
      chk_out("f1", 1'b1, 32'h4, 32'h11, 8'd2);
      step();
      chk_out("f2", 1'b1, 32'h8, 32'h22, 8'd3);

      // 2: stall three cycles then release
      outReady = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         chk_out("stall", 1'b1, 32'h8, 32'h22, 8'd3);
      end
      outReady = 1'b1;
      step();
      chk_out("rel", 1'b1, 32'hC, 32'h33, 8'd4);

      // 3: redirect while stalled
      outReady = 1'b0;
      step();
      chk_out("st2", 1'b1, 32'hC, 32'h33, 8'd4);
      redirectEn = 1'b1;
      redirectPc = 32'h40;
      step();
      redirectEn = 1'b0;
      outReady   = 1'b1;
      check("rd.valid", {31'h0, outValid}, 32'h0);
      check("rd.addr", {24'h0, memAddr}, 32'h10);
      check("rd.mis", {31'h0, misalignErr}, 32'h0);
      step();
      check("rd.warm", {31'h0, outValid}, 32'h0);
      step();
      chk_out("rd.f", 1'b1, 32'h40, 32'h110, 8'h11);
      check("rd.mis2", {31'h0, misalignErr}, 32'h0);

      // 4: misaligned redirect
      redirectEn = 1'b1;
      redirectPc = 32'h43;
      step();
      redirectEn = 1'b0;
      check("mis.pulse", {31'h0, misalignErr}, 32'h1);
      check("mis.addr", {24'h0, memAddr}, 32'h10);
      check("mis.valid", {31'h0, outValid}, 32'h0);
      step();
      check("mis.drop", {31'h0, misalignErr}, 32'h0);
      step();
      chk_out("mis.f", 1'b1, 32'h40, 32'h110, 8'h11);

      // 5: halt with pending output, then reset mid-cycle
      outReady = 1'b0;
      haltReq  = 1'b1;
      step();
      haltReq = 1'b0;
      check("h.halted", {31'h0, halted}, 32'h1);
      chk_out("h.hold", 1'b1, 32'h40, 32'h110, 8'h11);
      step();
      chk_out("h.hold2", 1'b1, 32'h40, 32'h110, 8'h11);
      outReady = 1'b1;
      step();
      check("h.drain", {31'h0, outValid}, 32'h0);
      check("h.halted2", {31'h0, halted}, 32'h1);
      redirectEn = 1'b1;
      redirectPc = 32'h80;
      step();
      redirectEn = 1'b0;
      check("h.ign.addr", {24'h0, memAddr}, 32'h11);
      check("h.ign.halt", {31'h0, halted}, 32'h1);
      check("h.ign.mis", {31'h0, misalignErr}, 32'h0);
      check("h.ign.valid", {31'h0, outValid}, 32'h0);
      #2 rst_n = 1'b0;
      #1;
      check("ar.halted", {31'h0, halted}, 32'h0);
      chk_out("ar", 1'b0, 32'h0, 32'h0, 8'd0);

      // 6: wrap of word address across 0x3FC -> 0x400
      @(negedge clk);
      rst_n      = 1'b1;
      redirectEn = 1'b1;
      redirectPc = 32'h3F8;
      step();
      redirectEn = 1'b0;
      check("w.addr0", {24'h0, memAddr}, 32'd254);
      step();
      check("w.warm", {31'h0, outValid}, 32'h0);
      check("w.addr1", {24'h0, memAddr}, 32'd254);
      step();
      chk_out("w0", 1'b1, 32'h3F8, 32'h10DE, 8'd255);
      step();
      chk_out("w1", 1'b1, 32'h3FC, 32'h10EF, 8'd0);
      step();
      chk_out("w2", 1'b1, 32'h400, 32'h0, 8'd1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
